ma_arbiter: RTL
===============

Name: ma_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 50-bit modular add/sub unit among NUM_REQ requesters.
- Accepts at most one operation per cycle over per-requester valid/ready handshakes.
- Drives the shared unit's operand, modulus and control ports from registers.
- Tracks in-flight operations with a tag pipeline and returns each result tagged with the originating requester id.
- Sits between the NTT/key-switch lane controllers and the shared modular adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 50, operand, modulus and result width.
- MA_LATENCY, 1, cycles from the unit sampling its inputs to its output holding the result (>=1).
- ID_W, 2, requester id width; must be >= clog2(NUM_REQ).
- CNT_W, 32, issue counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  arbitration enable; 0 = grant nothing, in-flight ops still complete
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
- req_op  in  NUM_REQ  per-requester op: 1 = modular add, 0 = modular subtract
- req_a  in  NUM_REQ*DATA_WIDTH  operand 0, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  NUM_REQ*DATA_WIDTH  operand 1, same packing as req_a
- req_mod  in  NUM_REQ*DATA_WIDTH  modulus, same packing as req_a
- ma_ctrl  out  1  to unit control (1 add, 0 sub)
- ma_modulus  out  DATA_WIDTH  to unit modulus
- ma_in0  out  DATA_WIDTH  to unit operand 0
- ma_in1  out  DATA_WIDTH  to unit operand 1
- ma_result  in  DATA_WIDTH  from unit output
- rsp_valid  out  1  result valid (one cycle per op)
- rsp_id  out  ID_W  requester id of the result
- rsp_data  out  DATA_WIDTH  result, equals ma_result
- busy  out  1  any op in flight
- issue_count  out  CNT_W  total accepted ops

Behaviour:
- Reset (async, rst=0):
  - ma_ctrl, ma_modulus, ma_in0, ma_in1 = 0.
  - Tag pipeline valid bits = 0, so rsp_valid = 0, rsp_id = 0, busy = 0.
  - issue_count = 0; round-robin pointer ptr = 0.
  - Reset mid-operation discards all in-flight ops; no response is produced for them. The shared unit shares the same rst.
- Grant (combinational from req_valid, ptr, en):
  - If en=1 and any req_valid is set, req_ready is one-hot on the first valid requester searching ptr, ptr+1, ... wrapping modulo NUM_REQ. Otherwise req_ready = 0.
  - req_ready never depends on req_ready.
  - Handshake on requester i = req_valid[i] & req_ready[i].
- Pointer: on a handshake with requester i, ptr <= (i+1) mod NUM_REQ. With no handshake, ptr holds.
- Issue (registered):
  - On a handshake in cycle t, at the edge ending t: ma_ctrl <= req_op[i], ma_in0 <= a_i, ma_in1 <= b_i, ma_modulus <= mod_i, tag stage0 <= {1, i}.
  - With no handshake, the ma_* registers hold their values (no toggling); tag stage0 valid <= 0.
- Tag pipeline:
  - Depth MA_LATENCY + 1 (stage0 aligned with the issue registers).
  - Shifts every cycle unconditionally; the response path has no backpressure, and the consumer must accept every rsp_valid.
- Response:
  - rsp_valid and rsp_id come from the last tag stage; rsp_data = ma_result, passed straight through.
  - Handshake in cycle t gives rsp_valid in cycle t + 1 + MA_LATENCY.
  - Throughput is one op per cycle; back-to-back ops return in order.
- busy = OR of all tag valid bits.
- issue_count increments by 1 per handshake and wraps at 2^CNT_W.
- Requester constraint: operands must be less than the modulus, held stable while valid=1 and not ready.
- Simultaneous events:
  - en falling while ops are in flight: responses still emitted.
  - Requester dropping valid with no grant: legal.
  - All requesters valid: strict rotation.

Test Plan (bench uses a behavioural modular add/sub model with MA_LATENCY=1):
- Reset then idle: rsp_valid=0, busy=0, req_ready=0, issue_count=0, ma_in0=0.
- Single op: req1 op=1, a=90, b=10, mod=97 → req_ready=4'b0010 in cycle t; rsp_valid=1, rsp_id=1, rsp_data=3 in cycle t+2; issue_count=1.
- Subtraction: req3 op=0, a=5, b=10, mod=97 → rsp_id=3, rsp_data=92 two cycles after handshake.
- All four valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle; issue_count=8.
- en=0 with req0 and req2 valid → req_ready=0 and no responses; raise en with ptr=2 → req2 granted first, then req0.
- Assert rst for 1 cycle with two ops in flight → no rsp_valid afterwards; busy=0; ptr=0 (next grant goes to req0 when all requesters are valid).

Source files
------------

// File: rtl/ma_arbiter_if.sv
// Bundle of requester handshakes, shared modular-adder ports and response/status signals
// seen by ma_arbiter. The slave modport is the arbiter's view of the bundle.
interface ma_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 50,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned CNT_W      = 32
);
    logic                          en;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_op;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_mod;

    logic                          ma_ctrl;
    logic [DATA_WIDTH-1:0]         ma_modulus;
    logic [DATA_WIDTH-1:0]         ma_in0;
    logic [DATA_WIDTH-1:0]         ma_in1;
    logic [DATA_WIDTH-1:0]         ma_result;

    logic                          rsp_valid;
    logic [ID_W-1:0]               rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          busy;
    logic [CNT_W-1:0]              issue_count;

    modport slave (
        input  en, req_valid, req_op, req_a, req_b, req_mod, ma_result,
        output req_ready, ma_ctrl, ma_modulus, ma_in0, ma_in1,
        output rsp_valid, rsp_id, rsp_data, busy, issue_count
    );

    modport master (
        output en, req_valid, req_op, req_a, req_b, req_mod, ma_result,
        input  req_ready, ma_ctrl, ma_modulus, ma_in0, ma_in1,
        input  rsp_valid, rsp_id, rsp_data, busy, issue_count
    );
endinterface

// File: rtl/ma_arbiter.sv
// Round-robin arbiter sharing one modular add/sub unit among NUM_REQ requesters; a tag
// pipeline follows each accepted op through the unit and labels its result with the id.
module ma_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 50,
    parameter int unsigned MA_LATENCY = 1,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned CNT_W      = 32
) (
    input logic            clk,
    input logic            rst,
    ma_arbiter_if.slave    bus
);

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_any;
    logic [ID_W-1:0]       grant_idx;
    int unsigned           scan_idx;

    logic                  ctrl_q;
    logic [DATA_WIDTH-1:0] in0_q, in1_q, mod_q;
    logic [DATA_WIDTH-1:0] sel_a, sel_b, sel_mod;
    logic [CNT_W-1:0]      cnt_q;

    logic [MA_LATENCY:0]   tag_vld_q;
    logic [ID_W-1:0]       tag_id_q [MA_LATENCY+1];

    // Scan starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        if (bus.en) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                scan_idx = 32'(ptr_q) + 32'(k);
                if (scan_idx >= NUM_REQ) begin
                    scan_idx = scan_idx - NUM_REQ;
                end
                if (!grant_any && bus.req_valid[ID_W'(scan_idx)]) begin
                    grant_any                 = 1'b1;
                    grant_idx                 = ID_W'(scan_idx);
                    grant[ID_W'(scan_idx)]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        sel_a   = bus.req_a[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        sel_b   = bus.req_b[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        sel_mod = bus.req_mod[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            ctrl_q <= 1'b0;
            in0_q  <= '0;
            in1_q  <= '0;
            mod_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            // Unit inputs only change on an accepted op so the shared adder does not toggle.
            if (grant_any) begin
                cnt_q  <= cnt_q + 1'b1;
                ctrl_q <= bus.req_op[grant_idx];
                in0_q  <= sel_a;
                in1_q  <= sel_b;
                mod_q  <= sel_mod;
            end
        end
    end

    // Stage 0 lines up with the issue registers; the last stage with the unit's result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_q <= '0;
            for (int s = 0; s <= int'(MA_LATENCY); s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_vld_q   <= {tag_vld_q[MA_LATENCY-1:0], grant_any};
            tag_id_q[0] <= grant_any ? grant_idx : '0;
            for (int s = 1; s <= int'(MA_LATENCY); s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    assign bus.req_ready   = grant;
    assign bus.ma_ctrl     = ctrl_q;
    assign bus.ma_in0      = in0_q;
    assign bus.ma_in1      = in1_q;
    assign bus.ma_modulus  = mod_q;
    assign bus.rsp_valid   = tag_vld_q[MA_LATENCY];
    assign bus.rsp_id      = tag_id_q[MA_LATENCY];
    assign bus.rsp_data    = bus.ma_result;
    assign bus.busy        = |tag_vld_q;
    assign bus.issue_count = cnt_q;

endmodule
